// File: rtl/axi_line_writer_if.sv
// AXI4 write-address, write-data and write-response channels for the line writer.
// A beat transfers on a rising edge where valid and ready are both high; once raised, valid and its payload hold until that edge.
interface axi_line_writer_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_line_writer.sv
// Write-buffer drain: turns one held line request into a single AXI4 INCR burst and pulses done_o on the B response.
module axi_line_writer #(
    parameter int              LINE_W = 128,
    parameter int              DATA_W = 32,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              done_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [2:0]        o_dbg_state,
    axi_line_writer_if.master axi
);
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [LINE_W-1:0] r_line;
    logic [31:0]       r_addr;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_wlast;
    logic              r_bready;
    logic              r_done;
    logic              r_busy;
    logic              r_err;
    logic              w_unused;

    // BID is not checked (single outstanding burst) and the line offset bits are discarded.
    assign w_unused = ^{axi.bid, addr_i[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_wlast   <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_addr    <= {addr_i[31:OFF_W], OFF_W'(0)};
                        r_line    <= data_i;
                        r_beat    <= '0;
                        r_awvalid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= (BEATS == 1);
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (axi.wready) begin
                        if (r_wlast) begin
                            r_wvalid <= 1'b0;
                            r_wlast  <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_beat  <= r_beat + BEAT_W'(1);
                            r_wlast <= (r_beat == BEAT_W'(BEATS - 2));
                        end
                    end
                end
                S_RESP: begin
                    if (axi.bvalid) begin
                        r_bready <= 1'b0;
                        r_done   <= 1'b1;
                        if (axi.bresp != 2'b00) r_err <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                // req_i is still high here until the buffer sees done; ignoring it prevents a replay.
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = r_addr;
    assign axi.awlen   = 8'(BEATS - 1);
    assign axi.awsize  = 3'($clog2(DATA_W / 8));
    assign axi.awburst = 2'b01;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_line[r_beat*DATA_W +: DATA_W];
    assign axi.wstrb   = '1;
    assign axi.wlast   = r_wlast;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;

    assign done_o      = r_done;
    assign busy_o      = r_busy;
    assign err_o       = r_err;
    assign o_dbg_state = r_state;
endmodule
